edf_egress_scheduler: RTL
=========================

Name:
edf_egress_scheduler

Overview:
- Per-egress-port frame scheduler for the 4-port switch.
- Arbitrates among 4 ingress queues that each hold a frame destined for this MII TX port.
- Picks the frame with the Earliest Deadline First (EDF); breaks ties by round-robin.
- Holds the grant for the whole frame, counting bytes accepted by the TX MAC, then enforces an inter-frame gap before the next arbitration.

Parameters:
- N_PORT, 4, number of requesters (ingress ports).
- DL_W, 16, deadline/timestamp width in bits.
- LEN_W, 11, frame length width in bytes (max 2047).
- IFG_CYC, 12, idle clock cycles inserted after each frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_PORT  per-ingress "frame pending" level.
- deadline  in  N_PORT*DL_W  per-ingress absolute deadline; slice i = [i*DL_W +: DL_W].
- flen  in  N_PORT*LEN_W  per-ingress frame length in bytes, excluding preamble/SFD.
- now  in  DL_W  global free-running timestamp; wraps modulo 2^DL_W.
- byte_ack  in  1  TX MAC accepted one byte of the granted frame this cycle.
- grant  out  N_PORT  one-hot grant to the ingress read mux.
- grant_id  out  2  encoded index of grant.
- busy  out  1  high in XFER or IFG.
- frame_done  out  1  one-cycle pulse on the last byte_ack of a frame.
- deq  out  N_PORT  one-cycle one-hot pulse to the granted queue, coincident with frame_done.

Behaviour:
- Reset (async, immediate) values: grant=0, grant_id=0, busy=0, frame_done=0, deq=0, state=IDLE, rr_ptr=0, remaining=0, ifg_cnt=0.
- States:
  - IDLE: if any req, evaluate the winner combinationally, register grant, load remaining=flen[win], go to XFER. Grant is visible one cycle after req is sampled.
  - XFER: each byte_ack decrements remaining. When remaining==1 and byte_ack: frame_done=1 and deq[win]=1 for that cycle; grant clears next cycle; rr_ptr=win+1 (mod N_PORT); ifg_cnt=IFG_CYC; go to IFG.
  - IFG: ifg_cnt decrements every cycle; grant=0; at ifg_cnt==1 go to IDLE. With IFG_CYC=0, go straight from XFER to IDLE.
- Urgency metric: slack_i = signed(deadline_i - now), computed in DL_W bits modulo 2^DL_W.
  - Smallest slack wins.
  - Negative slack (deadline already passed) is valid and is the most urgent.
  - Correct only while |deadline - now| < 2^(DL_W-1).
- Tie-break: among requesters with equal minimum slack, the first index at or after rr_ptr (circular scan) wins.
- Only requesters with req=1 participate. Changes to req, deadline or flen during XFER/IFG are ignored. A granted frame always completes and is never pre-empted.
- flen==0 is treated as 1 byte.
- byte_ack outside XFER is ignored.
- byte_ack may stall arbitrarily: remaining and grant are held.
- Simultaneous events:
  - Final byte_ack and a new req in the same cycle: no new grant until IFG completes.
  - The deq pulse lasts one cycle; if the queue still has frames, req stays high and it re-enters arbitration after IFG.
- Reset mid-XFER: grant drops asynchronously; the partial frame is abandoned and no deq is issued.
- grant_id is always consistent with grant (0 when grant==0).

Decomposition:
- Shared package switch_pkg holds:
  - constants N_PORT, DL_W, LEN_W, IFG_CYC defaults;
  - state enum (IDLE, XFER, IFG);
  - a function for the wrap-safe signed slack compare.
- One sub-module, edf_pick: combinational N_PORT-way minimum-slack selector with round-robin tie-break. Inputs: req, slacks, rr_ptr. Outputs: one-hot winner and valid.
- The FSM, counters and registers stay in edf_egress_scheduler.

Test Plan:
- Single request: now=0, req=0100, deadline[2]=100, flen[2]=4. Expect grant=0100 and grant_id=2 one cycle later. Four byte_acks produce frame_done+deq=0100 on the 4th. busy then stays high for 12 IFG cycles before returning to IDLE.
- EDF order: req=0011, deadline0=50, deadline1=30, now=0, flen=64 each. Expect port1 granted first, then port0 after its 64 acks plus IFG.
- Round-robin ties: req=1111 held, all deadlines 200, flen=2. Expect grant sequence 0,1,2,3,0 over consecutive frames.
- Wrap-around: now=16'hFFF0, deadline0=16'h0005 (slack 21), deadline1=16'hFFF8 (slack 8). Expect port1 wins. Then now=16'h0010, deadline2=16'h0008 (slack -8) versus deadline3=16'h0020: expect port2 wins.
- Stall and reset: flen=10. Hold byte_ack low for 20 cycles after the 3rd byte: grant held and no frame_done. Assert reset mid-frame: grant=0 immediately, no deq, rr_ptr=0. After release with req=1111 and equal deadlines, expect grant=0001.

Source files
------------

// File: rtl/switch_pkg.sv
// switch_pkg: shared constants, scheduler states and slack helpers for the egress scheduler.
package switch_pkg;
    localparam int N_PORT  = 4;
    localparam int DL_W    = 16;
    localparam int LEN_W   = 11;
    localparam int IFG_CYC = 12;
    localparam int ID_W    = $clog2(N_PORT);
    localparam int IFG_W   = (IFG_CYC < 2) ? 1 : $clog2(IFG_CYC + 1);

    typedef enum logic [1:0] {IDLE, XFER, IFG} state_e;

    // Slacks are two's complement in DL_W bits, so an overdue deadline sorts first.
    function automatic logic slack_lt(input logic [DL_W-1:0] a, input logic [DL_W-1:0] b);
        return $signed(a) < $signed(b);
    endfunction

    function automatic logic [ID_W-1:0] oh2idx(input logic [N_PORT-1:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_PORT; i++) idx |= oh[i] ? ID_W'(i) : '0;
        return idx;
    endfunction
endpackage

// File: rtl/edf_pick.sv
// edf_pick: minimum-slack selector; scanning from rr_ptr with strict less-than makes ties go round-robin.
module edf_pick
    import switch_pkg::*;
(
    input  logic [N_PORT-1:0]      req,
    input  logic [N_PORT*DL_W-1:0] slack,
    input  logic [ID_W-1:0]        rr_ptr,
    output logic [N_PORT-1:0]      win,
    output logic                   valid
);
    logic [DL_W-1:0] best;
    logic [ID_W-1:0] j;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        best  = '0;
        j     = rr_ptr;
        for (int k = 0; k < N_PORT; k++) begin
            if (req[j] && (!valid || slack_lt(slack[j*DL_W +: DL_W], best))) begin
                win    = '0;
                win[j] = 1'b1;
                valid  = 1'b1;
                best   = slack[j*DL_W +: DL_W];
            end
            j = (j == ID_W'(N_PORT - 1)) ? '0 : j + 1'b1;
        end
    end
endmodule

// File: rtl/edf_egress_scheduler.sv
// edf_egress_scheduler: EDF frame scheduler for one egress port; holds grant for a whole frame,
// then inserts an inter-frame gap before re-arbitrating.
module edf_egress_scheduler
    import switch_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_PORT-1:0]       req,
    input  logic [N_PORT*DL_W-1:0]  deadline,
    input  logic [N_PORT*LEN_W-1:0] flen,
    input  logic [DL_W-1:0]         now,
    input  logic                    byte_ack,
    output logic [N_PORT-1:0]       grant,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    frame_done,
    output logic [N_PORT-1:0]       deq
);
    state_e                 state_q, state_d;
    logic [N_PORT-1:0]      grant_q, grant_d, win;
    logic [ID_W-1:0]        grant_id_q, grant_id_d, rr_ptr_q, rr_ptr_d, win_id;
    logic [LEN_W-1:0]       remaining_q, remaining_d, win_len;
    logic [IFG_W-1:0]       ifg_cnt_q, ifg_cnt_d;
    logic [N_PORT*DL_W-1:0] slack;
    logic                   win_valid, last;

    for (genvar g = 0; g < N_PORT; g++) begin : g_slack
        assign slack[g*DL_W +: DL_W] = deadline[g*DL_W +: DL_W] - now;
    end

    edf_pick u_pick (
        .req    (req),
        .slack  (slack),
        .rr_ptr (rr_ptr_q),
        .win    (win),
        .valid  (win_valid)
    );

    assign win_id  = oh2idx(win);
    assign win_len = flen[win_id*LEN_W +: LEN_W];
    assign last    = (state_q == XFER) && byte_ack && (remaining_q == LEN_W'(1));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        remaining_d = remaining_q;
        ifg_cnt_d   = ifg_cnt_q;
        case (state_q)
            IDLE: if (win_valid) begin
                state_d     = XFER;
                grant_d     = win;
                grant_id_d  = win_id;
                remaining_d = (win_len == '0) ? LEN_W'(1) : win_len;
            end
            XFER: if (byte_ack) begin
                remaining_d = remaining_q - 1'b1;
                if (last) begin
                    grant_d    = '0;
                    grant_id_d = '0;
                    rr_ptr_d   = (grant_id_q == ID_W'(N_PORT - 1)) ? '0 : grant_id_q + 1'b1;
                    ifg_cnt_d  = IFG_W'(IFG_CYC);
                    state_d    = (IFG_CYC == 0) ? IDLE : IFG;
                end
            end
            IFG: begin
                ifg_cnt_d = ifg_cnt_q - 1'b1;
                state_d   = (ifg_cnt_q == IFG_W'(1)) ? IDLE : IFG;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            remaining_q <= '0;
            ifg_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            remaining_q <= remaining_d;
            ifg_cnt_q   <= ifg_cnt_d;
        end
    end

    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    assign busy       = state_q != IDLE;
    assign frame_done = last;
    assign deq        = last ? grant_q : '0;
endmodule
